// File: rtl/data_cache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
module data_cache_dm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 64,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        MEM,
    input  logic [DATA_W-1:0] Wdata,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Rdata,
    output logic              BUSY,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t            state;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS];
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_nx;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              rd;
    logic              wr;
    logic              hit;
    logic              last;

    assign tag     = Addr[ADDR_W-1 -: TAG_W];
    assign idx     = Addr[OFF_W +: IDX_W];
    assign off     = Addr[OFF_W-1:0];
    assign rd      = (MEM == 2'b01);
    assign wr      = MEM[1];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign beat_nx = beat + 1'b1;
    assign last    = &beat;

    always_comb begin
        BUSY = 1'b1;
        case (state)
            IDLE:    BUSY = wr || (rd && !hit);
            WDONE:   BUSY = 1'b0;
            default: BUSY = 1'b1;
        endcase
    end

    assign Rdata = (state == IDLE && rd && hit) ? data_q[{idx, off}] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_q   <= '0;
            beat      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= Addr;
                        mem_wdata <= Wdata;
                    end else if (rd && !hit) begin
                        // Line is overwritten word by word, so drop it now
                        state        <= FILL;
                        beat         <= '0;
                        valid_q[idx] <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        beat <= beat_nx;
                        if (last) begin
                            valid_q[idx] <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            mem_addr <= {tag, idx, beat_nx};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= WDONE;
                    end
                end
                WDONE: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_ack) begin
            if (state == FILL) begin
                data_q[{idx, beat}] <= mem_rdata;
                if (last) tag_q[idx] <= tag;
            end else if (state == WRITE && hit) begin
                data_q[{idx, off}] <= Wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic fill_done;

    // The held read that hits right after a refill is the miss retiring
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_done <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            fill_done <= (state == FILL) && mem_ack && last;
            if (state == IDLE && rd && hit && !fill_done && !(&hit_cnt))
                hit_cnt <= hit_cnt + 1'b1;
            if (state == IDLE && rd && !hit && !(&miss_cnt))
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/data_cache_dm.md
# data_cache_dm

Direct-mapped, write-through, no-write-allocate data cache for the pipeline's MEM stage. It replaces the flat single-cycle data memory model. It keeps the same CPU-side MEM/Wdata/Addr/Rdata/BUSY contract and adds a word-wide request/acknowledge port to backing memory. Read hits complete in the request cycle. Misses and all writes stall the pipeline through BUSY.

## Interface
- ADDR_W, 32, CPU word-address width.
- DATA_W, 32, data word width.
- LINES, 64, number of cache lines (power of 2, ≥2).
- WORDS, 4, words per line (power of 2, ≥2).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- MEM  in  2  CPU op: bit0 read, bit1 write; 2'b11 treated as write.
- Wdata  in  DATA_W  CPU write data.
- Addr  in  ADDR_W  CPU word address: offset = low log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining bits.
- Rdata  out  DATA_W  read data, valid when MEM==2'b01 and BUSY==0; 0 otherwise.
- BUSY  out  1  stall; CPU holds MEM/Addr/Wdata stable while high.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_W  word address of beat.
- mem_wdata  out  DATA_W  write beat data.
- mem_rdata  in  DATA_W  read beat data, valid with mem_ack.
- mem_ack  in  1  beat complete; single-cycle pulse.

## Operation
- Storage: per line a valid bit, a tag, and WORDS data words.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE, MEM==00: BUSY=0, no memory activity.
- IDLE, read hit (valid && tag match): BUSY=0; Rdata = cached word, combinational.
- IDLE, read miss: BUSY=1 combinationally. Next state FILL. Beat counter is cleared.
- FILL: mem_req=1, mem_we=0, mem_addr = {tag,index,beat}. On each mem_ack, mem_rdata is written to word[beat] and beat increments.
  - After ack of beat WORDS-1: tag is written, valid is set, state returns to IDLE.
  - The held read then hits; BUSY drops and Rdata is valid.
  - BUSY=1 throughout FILL.
- IDLE, write (MEM[1]=1): BUSY=1. Next state WRITE.
- WRITE: mem_req=1, mem_we=1, mem_addr=Addr, mem_wdata=Wdata; BUSY=1.
  - On mem_ack, a hit also updates the cached word; a miss leaves the cache unchanged (no allocate).
  - Next state WDONE.
- WDONE: BUSY=0 for exactly one cycle and the write retires; the CPU advances. Next state IDLE regardless of MEM.
- mem_req, mem_addr, mem_we and mem_wdata stay stable from assertion until the cycle mem_ack is sampled. mem_req deasserts on the edge after the final ack.
- mem_ack outside FILL/WRITE is ignored.
- A read of a line being filled cannot occur, because the CPU is stalled.

## Timing
- Reset values:
  - BUSY=0 and Rdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State IDLE and all valid bits cleared.
- Reset asserted mid-FILL or mid-WRITE aborts the operation. mem_req is 0 after that edge and the partial line is left invalid.
- Read hit latency: 0 cycles (same-cycle Rdata).
- Read miss, memory acks in the cycle after each request: BUSY high for 2·WORDS+1 cycles.
  - Memory with N-cycle ack: WORDS·(N+1)+1 cycles.
- Write, memory acks the cycle after request: BUSY high for 3 cycles (IDLE detect, WRITE req, WRITE ack), then 1 cycle low in WDONE.
- Tag/valid/data writes take effect on the clock edge and are visible to the next cycle's compare.

## Configuration
- DCACHE_STATS_EN defined: the block adds outputs hit_cnt and miss_cnt (32 bits each, reset 0, saturating at all-ones).
  - hit_cnt increments once per retired read hit (IDLE, read, hit, BUSY=0).
  - miss_cnt increments once per transition IDLE→FILL.
  - Writes are counted in neither.
- DCACHE_STATS_EN undefined: no counter logic and no counter ports.

## Test plan
- Reset, then read Addr=0x10 with memory returning beat value = address: BUSY high 9 cycles (WORDS=4, 1-cycle ack); mem_addr sequence 0x10,0x11,0x12,0x13; then Rdata=0x10.
- Following read of Addr=0x13: BUSY=0 and Rdata=0x13 in the same cycle; no mem_req.
- Write Wdata=0xDEADBEEF to Addr=0x11 (hit): exactly one write beat with mem_we=1 and mem_addr=0x11, then WDONE. A subsequent read of 0x11 hits with 0xDEADBEEF.
- Write to Addr=0x400 (miss): one write beat. A following read of 0x400 misses and fills.
- Conflicting addresses 0x10 and 0x10+WORDS·LINES read alternately: every access misses and refills; with DCACHE_STATS_EN, miss_cnt=4 after 4 reads and hit_cnt=0.
- Assert rst_n=0 during beat 2 of a fill: mem_req=0 after the edge. A re-read of the same address misses and performs a full 4-beat fill.
